// File: rtl/d_sramlike_bridge.sv
// Data-side bridge from the mem-stage SRAM port to the SRAM-like req/addr_ok/data_ok bus.
// Optional stall-cycle counter is built when DSRAM_PERF_CNT_EN is defined.
module d_sramlike_bridge #(
    parameter logic [1:0] RD_SIZE  = 2'b10,
    parameter bit         ALIGN_RD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        pipe_stall,
    input  logic        flush_except,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state_reg, state_next;
    logic        go;
    logic        wr_in;
    logic [1:0]  size_in;
    logic [31:0] addr_in;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        wr_reg;
    logic [31:0] rdata_reg;

    assign go    = data_sram_en & ~flush_except;
    assign wr_in = |data_sram_wen;

    always_comb begin
        size_in = 2'd2;
        case (data_sram_wen)
            4'b0000:                            size_in = RD_SIZE;
            4'b1111:                            size_in = 2'd2;
            4'b0011, 4'b1100:                   size_in = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_in = 2'd0;
            default:                            size_in = 2'd2;
        endcase
    end

    // Only the two low address bits are ever masked, and only for reads.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_addr
            if (gi < 2) begin : g_lo
                assign addr_in[gi] = (ALIGN_RD && !wr_in) ? 1'b0 : data_sram_addr[gi];
            end else begin : g_hi
                assign addr_in[gi] = data_sram_addr[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (go) state_next = data_addr_ok ? DATA : ADDR;
            ADDR: if (data_addr_ok) state_next = DATA;
            DATA: if (data_data_ok) state_next = DONE;
            DONE: if (!pipe_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // IDLE drives the bus straight from the pipeline; later states replay the held copy.
    always_comb begin
        data_req   = 1'b0;
        data_wr    = wr_reg;
        data_size  = size_reg;
        data_addr  = addr_reg;
        data_wdata = wdata_reg;
        d_stall    = 1'b0;
        case (state_reg)
            IDLE: begin
                data_req   = go;
                data_wr    = wr_in;
                data_size  = size_in;
                data_addr  = addr_in;
                data_wdata = data_sram_wdata;
                d_stall    = go;
            end
            ADDR: begin
                data_req = 1'b1;
                d_stall  = data_sram_en;
            end
            DATA: begin
                d_stall = data_sram_en;
            end
            DONE: begin
                d_stall = 1'b0;
            end
            default: begin
                d_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            size_reg  <= 2'd0;
            wr_reg    <= 1'b0;
        end else if (state_reg == IDLE && go) begin
            addr_reg  <= addr_in;
            wdata_reg <= data_sram_wdata;
            size_reg  <= size_in;
            wr_reg    <= wr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= 32'h0;
        end else if (state_reg == DATA && data_data_ok && !wr_reg) begin
            rdata_reg <= data_rdata;
        end
    end

    assign data_sram_rdata = rdata_reg;

`ifdef DSRAM_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= 32'h0;
        end else if (d_stall && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
`else
    assign perf_stall_cnt = 32'h0;
`endif

endmodule
